// File: rtl/world_tile_writer_if.sv
// Request channel from game logic plus the write-side port of the world tile RAM.
// The writer uses the slave view; the requester/RAM side uses the master view.
interface world_tile_writer_if;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_col;
    logic [4:0]  req_row;
    logic [1:0]  req_kind;
    logic [4:0]  req_tile;
    logic [10:0] mem_addr;
    logic [4:0]  mem_rd_data;
    logic        mem_wr_en;
    logic [4:0]  mem_wr_data;

    modport master (
        output req_valid, req_col, req_row, req_kind, req_tile, mem_rd_data,
        input  req_ready, mem_addr, mem_wr_en, mem_wr_data
    );

    modport slave (
        input  req_valid, req_col, req_row, req_kind, req_tile, mem_rd_data,
        output req_ready, mem_addr, mem_wr_en, mem_wr_data
    );
endinterface

// File: rtl/world_tile_writer.sv
// Queues gameplay tile edits and applies them to the world RAM as serial
// read-modify-write operations, starting new ones only during vertical blanking.
module world_tile_writer #(
    parameter int         DEPTH    = 4,
    parameter int         COLS     = 40,
    parameter int         ROWS     = 30,
    parameter logic [4:0] T_QBLOCK = 5'd4,
    parameter logic [4:0] T_USED   = 5'd6,
    parameter logic [4:0] T_BRICK  = 5'd2,
    parameter logic [4:0] T_EMPTY  = 5'd1
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               vblank,
    world_tile_writer_if.slave bus,
    output logic               coin_pulse,
    output logic               drop_pulse,
    output logic               busy,
    output logic [4:0]         pending
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, READ, WAIT, APPLY} state_t;

    typedef struct packed {
        logic [10:0] addr;
        logic [1:0]  kind;
        logic [4:0]  tile;
    } entry_t;

    // row*40 + col without a multiplier: row*32 + row*8 + col
    function automatic logic [10:0] cell_addr(input logic [4:0] row, input logic [5:0] col);
        return {1'b0, row, 5'b0} + {3'b0, row, 3'b0} + {5'b0, col};
    endfunction

    entry_t        fifo_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [4:0]    count_q, count_d;
    state_t        state_q, state_d;
    logic [10:0]   addr_q, addr_d;
    logic [4:0]    wdata_q, wdata_d;
    logic          due_q, due_d;
    logic          coin_q, coin_d;
    logic          drop_q, drop_d;
    logic [1:0]    hold_kind_q;
    logic [4:0]    hold_tile_q;

    logic xfer, req_ok, push, pop;

    assign bus.req_ready = (count_q != 5'(DEPTH));
    assign xfer          = bus.req_valid && bus.req_ready;
    assign req_ok        = (bus.req_col < 6'(COLS)) && (bus.req_row < 5'(ROWS))
                         && (bus.req_kind != 2'd3);
    assign push          = xfer && req_ok;
    assign drop_d        = xfer && !req_ok;
    assign pop           = (state_q == IDLE) && vblank && (count_q != 5'd0);
    assign count_d       = count_q + {4'b0, push} - {4'b0, pop};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        due_d   = due_q;
        coin_d  = coin_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    addr_d  = fifo_q[rd_ptr_q].addr;
                    state_d = READ;
                end
            end
            READ: state_d = WAIT;
            WAIT: begin
                due_d   = 1'b0;
                coin_d  = 1'b0;
                wdata_d = bus.mem_rd_data;
                case (hold_kind_q)
                    2'd0: if (bus.mem_rd_data == T_QBLOCK) begin
                        due_d   = 1'b1;
                        coin_d  = 1'b1;
                        wdata_d = T_USED;
                    end
                    2'd1: if (bus.mem_rd_data == T_BRICK) begin
                        due_d   = 1'b1;
                        wdata_d = T_EMPTY;
                    end
                    2'd2: begin
                        due_d   = 1'b1;
                        wdata_d = hold_tile_q;
                    end
                    default: ;
                endcase
                state_d = APPLY;
            end
            APPLY: begin
                due_d   = 1'b0;
                coin_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 5'd0;
            addr_q   <= 11'd0;
            wdata_q  <= 5'd0;
            due_q    <= 1'b0;
            coin_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            due_q   <= due_d;
            coin_q  <= coin_d;
            drop_q  <= drop_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Queue storage and the popped request carry no reset; only control is reset.
    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{addr: cell_addr(bus.req_row, bus.req_col),
                                  kind: bus.req_kind, tile: bus.req_tile};
        end
        if (pop) begin
            hold_kind_q <= fifo_q[rd_ptr_q].kind;
            hold_tile_q <= fifo_q[rd_ptr_q].tile;
        end
    end

    // The write strobe is decoded from state so an async reset removes it at once.
    assign bus.mem_wr_en   = (state_q == APPLY) && due_q;
    assign bus.mem_wr_data = wdata_q;
    assign bus.mem_addr    = addr_q;
    assign coin_pulse      = (state_q == APPLY) && coin_q;
    assign drop_pulse      = drop_q;
    assign busy            = (state_q != IDLE);
    assign pending         = count_q;

endmodule
